multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the 16-bit CPU. It replaces the single-cycle opcode decoder with a sequenced FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller. It adds ready/acknowledge handshakes to instruction and data memory, bounded wait-state timeouts, illegal-opcode detection and a per-instruction retire pulse. It sits between the instruction register, the PC logic, the register file, the ALU and the memory ports.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/opcode_decoder.sv | 54 +++++
 rtl/multicycle_control_unit.sv | 144 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, opcodes and control bundle for the multi-cycle controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ANDI = 3'b001;
  localparam logic [2:0] OP_ORI  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SLTI = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_BNE  = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_t;

  // Datapath controls plus the instruction-class flags the FSM sequences on
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_t alu_op;
    logic    mem_to_reg;
    logic    is_mem;
    logic    is_store;
    logic    is_branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    alu_op:     ALUOP_MEM,
    mem_to_reg: 1'b0,
    is_mem:     1'b0,
    is_store:   1'b0,
    is_branch:  1'b0
  };

  function automatic int cnt_width(input int max_val);
    return (max_val <= 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational opcode to control-bundle map with illegal-opcode flag
module opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output ctrl_t               o_ctrl,
  output logic                o_illegal
);

  logic w_upper_set;

  generate
    if (OPCODE_W > 3) begin : g_upper
      assign w_upper_set = |i_opcode[OPCODE_W-1:3];
    end else begin : g_no_upper
      assign w_upper_set = 1'b0;
    end
  endgenerate

  always_comb begin
    o_ctrl = CTRL_NOP;
    case (i_opcode[2:0])
      OP_R: begin
        o_ctrl.reg_dst = 1'b1;
        o_ctrl.alu_op  = ALUOP_R;
      end
      OP_ANDI, OP_ORI, OP_ADDI, OP_SLTI: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.alu_op  = ALUOP_I;
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.is_mem     = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.is_mem   = 1'b1;
        o_ctrl.is_store = 1'b1;
      end
      OP_BNE: begin
        o_ctrl.alu_op    = ALUOP_BR;
        o_ctrl.is_branch = 1'b1;
      end
    endcase
    // An illegal opcode must never leak partial controls into the datapath
    if (w_upper_set) o_ctrl = CTRL_NOP;
  end

  assign o_illegal = w_upper_set;

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory handshakes
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_dst,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int               CNT_W   = cnt_width(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  ctrl_t            r_ctrl;
  ctrl_t            w_dec_ctrl;
  logic             w_illegal;
  logic             w_timeout;

  opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_opcode_decoder (
    .i_opcode  (opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_illegal)
  );

  assign w_timeout = (r_wait_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Any state change clears the count, so FETCH and MEMORY always start from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_FETCH || r_state == S_MEMORY) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_ctrl <= CTRL_NOP;
    else if (r_state == S_DECODE && !w_illegal) r_ctrl <= w_dec_ctrl;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        w_state_nxt = w_illegal ? S_FAULT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (r_ctrl.is_branch) begin
          pc_write    = ~zero;
          pc_src      = ~zero;
          instr_done  = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (r_ctrl.is_mem) begin
          w_state_nxt = S_MEMORY;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req  = 1'b1;
        mem_write = r_ctrl.is_store;
        if (dmem_ack) begin
          // Stores retire on the ack itself; loads still need the writeback cycle
          if (r_ctrl.is_store) begin
            instr_done  = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        reg_write   = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  assign reg_dst    = r_ctrl.reg_dst;
  assign alu_src    = r_ctrl.alu_src;
  assign alu_op     = r_ctrl.alu_op;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int OPW = 4;
  localparam int TMO = 15;

  logic           clk;
  logic           rst_n;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           imem_ack;
  logic           dmem_ack;
  logic           imem_req;
  logic           dmem_req;
  logic           mem_write;
  logic           ir_write;
  logic           pc_write;
  logic           pc_src;
  logic           reg_dst;
  logic           alu_src;
  logic [1:0]     alu_op;
  logic           mem_to_reg;
  logic           reg_write;
  logic           instr_done;
  logic           fault;
  logic [2:0]     state;

  multicycle_control_unit #(
    .OPCODE_W    (OPW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .fault      (fault),
    .state      (state)
  );

  // One clock cycle of stimulus and the outputs the specification demands for it
  typedef struct {
    logic [OPW-1:0] opc;
    logic           iack;
    logic           dack;
    logic           z;
    logic [11:0]    exp;
    logic [4:0]     ctl;
  } cyc_t;

  int         n_checks;
  int         n_fail;
  logic [4:0] cur_ctl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    return OPW'($urandom);
  endfunction

  function automatic logic [11:0] outs(input int st, input bit ireq, input bit dreq, input bit mw,
                                       input bit irw, input bit pcw, input bit pcs, input bit rw,
                                       input bit done, input bit flt);
    logic [2:0] s;
    s = st[2:0];
    return {s, ireq, dreq, mw, irw, pcw, pcs, rw, done, flt};
  endfunction

  // {reg_dst, alu_src, alu_op, mem_to_reg} from the opcode table
  function automatic logic [4:0] model_ctl(input logic [2:0] op);
    case (op)
      3'd0:    return 5'b1_0_10_0;
      3'd5:    return 5'b0_1_00_1;
      3'd6:    return 5'b0_1_00_0;
      3'd7:    return 5'b0_0_01_0;
      default: return 5'b0_1_11_0;
    endcase
  endfunction

  function automatic int model_latency(input logic [OPW-1:0] op, input int iw, input int dw);
    if (op == 4'd7) return 3 + iw;
    if (op == 4'd5) return 5 + iw + dw;
    if (op == 4'd6) return 4 + iw + dw;
    return 4 + iw;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cur_ctl = '0;
  endtask

  task automatic run_instr(input string name, input logic [OPW-1:0] op, input logic z,
                           input int iw, input int dw, input int stop_after,
                           output int done_at, output int rw_cnt, output int ireq_cnt);
    cyc_t       tr[$];
    cyc_t       c;
    logic [11:0] obs;
    logic [4:0]  octl;
    bit         is_br;
    bit         is_mem;
    bit         is_st;
    bit         dead;
    is_br  = (op == 4'd7);
    is_st  = (op == 4'd6);
    is_mem = (op == 4'd5) || is_st;
    dead   = 1'b0;
    for (int i = 0; i <= iw && i <= TMO; i++) begin
      c.opc = rnd_op(); c.iack = (i == iw); c.dack = rb(); c.z = rb(); c.ctl = cur_ctl;
      c.exp = outs(0, 1, 0, 0, c.iack, c.iack, 0, 0, 0, 0);
      tr.push_back(c);
    end
    if (iw > TMO) begin
      dead = 1'b1;
    end else begin
      c.opc = op; c.iack = rb(); c.dack = rb(); c.z = rb(); c.ctl = cur_ctl;
      c.exp = outs(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tr.push_back(c);
      if ((op >> 3) != 0) begin
        dead = 1'b1;
      end else begin
        cur_ctl = model_ctl(op[2:0]);
        c.opc = rnd_op(); c.iack = rb(); c.dack = rb(); c.z = is_br ? z : rb(); c.ctl = cur_ctl;
        c.exp = outs(2, 0, 0, 0, 0, is_br && !z, is_br && !z, 0, is_br, 0);
        tr.push_back(c);
        if (is_mem) begin
          for (int i = 0; i <= dw && i <= TMO; i++) begin
            c.opc = rnd_op(); c.iack = rb(); c.dack = (i == dw); c.z = rb(); c.ctl = cur_ctl;
            c.exp = outs(3, 0, 1, is_st, 0, 0, 0, 0, is_st && (i == dw), 0);
            tr.push_back(c);
          end
          if (dw > TMO) dead = 1'b1;
        end
        if (!is_br && !is_st && !dead) begin
          c.opc = rnd_op(); c.iack = rb(); c.dack = rb(); c.z = rb(); c.ctl = cur_ctl;
          c.exp = outs(4, 0, 0, 0, 0, 0, 0, 1, 1, 0);
          tr.push_back(c);
        end
      end
    end
    if (dead) begin
      for (int i = 0; i < 3; i++) begin
        c.opc = rnd_op(); c.iack = rb(); c.dack = rb(); c.z = rb(); c.ctl = cur_ctl;
        c.exp = outs(5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tr.push_back(c);
      end
    end

    done_at  = 0;
    rw_cnt   = 0;
    ireq_cnt = 0;
    foreach (tr[k]) begin
      if (stop_after > 0 && k >= stop_after) break;
      opcode   = tr[k].opc;
      imem_ack = tr[k].iack;
      dmem_ack = tr[k].dack;
      zero     = tr[k].z;
      @(negedge clk);
      obs = {state, imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, reg_write, instr_done, fault};
      n_checks++;
      if (obs !== tr[k].exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d outputs {state,ireq,dreq,mw,irw,pcw,pcs,rw,done,fault}: got %b expected %b",
                 name, k + 1, obs, tr[k].exp);
      end
      octl = {reg_dst, alu_src, alu_op, mem_to_reg};
      n_checks++;
      if (octl !== tr[k].ctl) begin
        n_fail++;
        $display("FAIL %s cycle %0d controls {reg_dst,alu_src,alu_op,mem_to_reg}: got %b expected %b",
                 name, k + 1, octl, tr[k].ctl);
      end
      if (instr_done === 1'b1 && done_at == 0) done_at = k + 1;
      if (reg_write === 1'b1) rw_cnt++;
      if (imem_req === 1'b1) ireq_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    n_checks++;
    if ({state, dmem_req, reg_write, instr_done, fault} !== 7'b000_0000) begin
      n_fail++;
      $display("FAIL reset_state {state,dreq,rw,done,fault}: got %b expected 0000000",
               {state, dmem_req, reg_write, instr_done, fault});
    end
    n_checks++;
    if ({reg_dst, alu_src, alu_op, mem_to_reg} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {reg_dst, alu_src, alu_op, mem_to_reg});
    end
    do_reset();
  endtask

  task automatic test_rtype();
    int d, rw, ir;
    run_instr("rtype", 4'd0, rb(), 0, 0, 0, d, rw, ir);
    n_checks++;
    if (d != 4) begin n_fail++; $display("FAIL rtype_latency: got %0d expected 4", d); end
    n_checks++;
    if (rw != 1) begin n_fail++; $display("FAIL rtype_reg_write_cycles: got %0d expected 1", rw); end
  endtask

  task automatic test_lw();
    int d, rw, ir;
    run_instr("lw", 4'd5, rb(), 0, 3, 0, d, rw, ir);
    n_checks++;
    if (d != 8) begin n_fail++; $display("FAIL lw_latency: got %0d expected 8", d); end
    n_checks++;
    if (rw != 1) begin n_fail++; $display("FAIL lw_reg_write_cycles: got %0d expected 1", rw); end
  endtask

  task automatic test_bne();
    int d, rw, ir;
    for (int zi = 0; zi < 2; zi++) begin
      run_instr(zi == 0 ? "bne_taken" : "bne_not_taken", 4'd7, 1'(zi), 0, 0, 0, d, rw, ir);
      n_checks++;
      if (d != 3) begin n_fail++; $display("FAIL bne_latency zero=%0d: got %0d expected 3", zi, d); end
      n_checks++;
      if (rw != 0) begin n_fail++; $display("FAIL bne_reg_write zero=%0d: got %0d expected 0", zi, rw); end
    end
  endtask

  task automatic test_back_to_back();
    int d, rw, ir, dw, iw;
    dw = $urandom_range(0, 3);
    iw = $urandom_range(0, 2);
    run_instr("b2b_sw", 4'd6, rb(), 0, dw, 0, d, rw, ir);
    n_checks++;
    if (d != 4 + dw) begin n_fail++; $display("FAIL b2b_sw_latency: got %0d expected %0d", d, 4 + dw); end
    run_instr("b2b_addi", 4'd3, rb(), iw, 0, 0, d, rw, ir);
    n_checks++;
    if (d != 4 + iw) begin n_fail++; $display("FAIL b2b_addi_latency: got %0d expected %0d", d, 4 + iw); end
  endtask

  task automatic test_random();
    int d, rw, ir, iw, dw, exp_rw;
    logic [OPW-1:0] op;
    for (int n = 0; n < 24; n++) begin
      op = OPW'($urandom_range(0, 7));
      iw = $urandom_range(0, 4);
      dw = $urandom_range(0, 4);
      run_instr("random", op, rb(), iw, dw, 0, d, rw, ir);
      exp_rw = (op == 4'd6 || op == 4'd7) ? 0 : 1;
      n_checks++;
      if (d != model_latency(op, iw, dw) || rw != exp_rw) begin
        n_fail++;
        $display("FAIL random op=%0d iw=%0d dw=%0d: latency %0d reg_write %0d expected %0d %0d",
                 op, iw, dw, d, rw, model_latency(op, iw, dw), exp_rw);
      end
    end
  endtask

  task automatic test_illegal();
    int d, rw, ir;
    run_instr("illegal", 4'b1000 | OPW'($urandom_range(0, 7)), rb(), 0, 0, 0, d, rw, ir);
    n_checks++;
    if (d != 0 || ir != 1) begin
      n_fail++;
      $display("FAIL illegal_requests: done_at %0d imem_req cycles %0d expected 0 1", d, ir);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_async_clear: state %0d fault %b expected 0 0", state, fault);
    end
    do_reset();
  endtask

  task automatic test_timeouts();
    int d, rw, ir;
    run_instr("imem_timeout", 4'd0, rb(), 16, 0, 0, d, rw, ir);
    n_checks++;
    if (ir != 16 || d != 0) begin
      n_fail++;
      $display("FAIL imem_timeout: imem_req cycles %0d done_at %0d expected 16 0", ir, d);
    end
    do_reset();
    run_instr("dmem_timeout", 4'd5, rb(), 0, 16, 0, d, rw, ir);
    n_checks++;
    if (d != 0 || rw != 0) begin
      n_fail++;
      $display("FAIL dmem_timeout: done_at %0d reg_write %0d expected 0 0", d, rw);
    end
    do_reset();
    run_instr("edge_wait", 4'd6, rb(), 15, 15, 0, d, rw, ir);
    n_checks++;
    if (d != 34) begin n_fail++; $display("FAIL edge_wait_latency: got %0d expected 34", d); end
  endtask

  task automatic test_reset_mid_mem();
    int d, rw, ir;
    run_instr("mid_mem", 4'd5, rb(), 0, 6, 4, d, rw, ir);
    #2;
    n_checks++;
    if (dmem_req !== 1'b1 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_mem_before: dmem_req %b state %0d expected 1 3", dmem_req, state);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_mem_async_reset: dmem_req %b state %0d expected 0 0", dmem_req, state);
    end
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_ctl  = '0;
    rst_n    = 1'b0;
    opcode   = '0;
    zero     = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_bne();
    test_back_to_back();
    test_random();
    test_illegal();
    test_timeouts();
    test_reset_mid_mem();
    test_rtype();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
